// File: rtl/io_seg_scan.sv
// io_seg_scan: scans one snapshotted 32-bit output port onto a multiplexed
// common-anode 7-segment display, one hex nibble per digit slot.
// Optional build macro: LEADING_ZERO_BLANK_EN (blank leading zero digits).
module io_seg_scan #(
  parameter int CLK_DIV        = 50000,
  parameter int NUM_DIGITS     = 8,
  parameter int SEG_ACTIVE_LOW = 1
) (
  input  logic                  io_clk,
  input  logic                  clr,
  input  logic [31:0]           in_port0,
  input  logic [31:0]           in_port1,
  input  logic [31:0]           in_port2,
  input  logic [1:0]            disp_sel,
  input  logic                  disp_en,
  output logic [NUM_DIGITS-1:0] an,
  output logic [6:0]            seg,
  output logic                  dp
);
  localparam int CW = $clog2(CLK_DIV);
  localparam int DW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);
  localparam logic [DW-1:0] DIG_LAST = DW'(NUM_DIGITS - 1);
  localparam logic [DW-1:0] DIG_DP   = DW'(NUM_DIGITS / 2);
  // Everything is built active-low internally; these masks flip it for active-high boards.
  localparam logic [NUM_DIGITS-1:0] INV_AN  = (SEG_ACTIVE_LOW != 0) ? '0 : '1;
  localparam logic [6:0]            INV_SEG = (SEG_ACTIVE_LOW != 0) ? 7'h00 : 7'h7F;
  localparam logic                  INV_DP  = (SEG_ACTIVE_LOW == 0);

  logic [CW-1:0]         cnt;
  logic [DW-1:0]         digit_idx;
  logic [31:0]           frame;
  logic [31:0]           port_pick;
  logic                  tick;
  logic [3:0]            nib;
  logic                  blank;
  logic [NUM_DIGITS-1:0] an_raw;
  logic [6:0]            seg_raw;
  logic                  dp_raw;

  // Active-low hex font, segments {g,f,e,d,c,b,a}.
  function automatic logic [6:0] font(input logic [3:0] n);
    case (n)
      4'h0: font = 7'h40;  4'h1: font = 7'h79;  4'h2: font = 7'h24;  4'h3: font = 7'h30;
      4'h4: font = 7'h19;  4'h5: font = 7'h12;  4'h6: font = 7'h02;  4'h7: font = 7'h78;
      4'h8: font = 7'h00;  4'h9: font = 7'h10;  4'hA: font = 7'h08;  4'hB: font = 7'h03;
      4'hC: font = 7'h46;  4'hD: font = 7'h21;  4'hE: font = 7'h06;  default: font = 7'h0E;
    endcase
  endfunction

  assign tick = (cnt == CNT_LAST);
  assign nib  = 4'(frame >> {digit_idx, 2'b00});

  // Port select; code 3 aliases port 0.
  always_comb begin
    port_pick = in_port0;
    case (disp_sel)
      2'd1:    port_pick = in_port1;
      2'd2:    port_pick = in_port2;
      default: port_pick = in_port0;
    endcase
  end

`ifdef LEADING_ZERO_BLANK_EN
  // nz[k]: something nonzero at or above nibble k, so digit k must stay lit.
  logic [NUM_DIGITS-1:0] nz;
  for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_nz
    assign nz[k] = |frame[31:4*k];
  end
  assign blank = (digit_idx != '0) && !nz[digit_idx];
`else
  assign blank = 1'b0;
`endif

  // Prescaler, digit scan, and once-per-frame snapshot so a frame never tears.
  always_ff @(posedge io_clk or posedge clr) begin
    if (clr) begin
      cnt       <= '0;
      digit_idx <= '0;
      frame     <= '0;
    end else begin
      cnt <= tick ? '0 : cnt + 1'b1;
      if (tick) begin
        if (digit_idx == DIG_LAST) begin
          digit_idx <= '0;
          frame     <= port_pick;
        end else begin
          digit_idx <= digit_idx + 1'b1;
        end
      end
    end
  end

  // Next display pattern (active-low), dark by default.
  always_comb begin
    an_raw  = '1;
    seg_raw = 7'h7F;
    dp_raw  = 1'b1;
    if (disp_en && !blank) begin
      an_raw  = ~(NUM_DIGITS'(1) << digit_idx);
      seg_raw = font(nib);
      dp_raw  = (digit_idx != DIG_DP);
    end
  end

  // Registered outputs: an/seg/dp change together on one edge, so no inter-digit glitches.
  always_ff @(posedge io_clk or posedge clr) begin
    if (clr) begin
      an  <= '1 ^ INV_AN;
      seg <= 7'h7F ^ INV_SEG;
      dp  <= 1'b1 ^ INV_DP;
    end else begin
      an  <= an_raw ^ INV_AN;
      seg <= seg_raw ^ INV_SEG;
      dp  <= dp_raw ^ INV_DP;
    end
  end
endmodule

// File: tb/tb_io_seg_scan.sv
// Bench for io_seg_scan (CLK_DIV=4, 8 digits, active-low): a reference model
// pushes the expected pattern every clock, and each negedge pops and compares it;
// directed checks pin the key cycles to constants.
module tb_io_seg_scan;
  logic        io_clk = 1'b0;
  logic        clr = 1'b1;
  logic [31:0] in_port0 = '0, in_port1 = '0, in_port2 = '0;
  logic [1:0]  disp_sel = 2'd0;
  logic        disp_en = 1'b1;
  logic [7:0]  an;
  logic [6:0]  seg;
  logic        dp;

  int n_assert = 0;
  int n_fail   = 0;
  int c        = 0;

  typedef struct packed {logic [7:0] an; logic [6:0] seg; logic dp;} out_t;
  out_t q[$];

  int          m_cnt = 0, m_idx = 0;
  logic [31:0] m_frame = '0;

  logic [6:0] seg_1234abcd [8] = '{7'h21, 7'h46, 7'h03, 7'h08, 7'h19, 7'h30, 7'h24, 7'h79};

  always #5 io_clk = ~io_clk;

  io_seg_scan #(.CLK_DIV(4), .NUM_DIGITS(8), .SEG_ACTIVE_LOW(1)) dut (
    .io_clk(io_clk), .clr(clr), .in_port0(in_port0), .in_port1(in_port1),
    .in_port2(in_port2), .disp_sel(disp_sel), .disp_en(disp_en),
    .an(an), .seg(seg), .dp(dp)
  );

  function automatic logic [6:0] font(input logic [3:0] n);
    case (n)
      4'h0: return 7'h40; 4'h1: return 7'h79; 4'h2: return 7'h24; 4'h3: return 7'h30;
      4'h4: return 7'h19; 4'h5: return 7'h12; 4'h6: return 7'h02; 4'h7: return 7'h78;
      4'h8: return 7'h00; 4'h9: return 7'h10; 4'hA: return 7'h08; 4'hB: return 7'h03;
      4'hC: return 7'h46; 4'hD: return 7'h21; 4'hE: return 7'h06; default: return 7'h0E;
    endcase
  endfunction

  function automatic out_t exp_out(input int idx, input logic [31:0] fr, input logic en);
    out_t e;
    logic blank = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
    blank = (idx != 0) && ((fr >> (4 * idx)) == 32'h0);
`endif
    if (!en || blank) e = {8'hFF, 7'h7F, 1'b1};
    else e = {~(8'h1 << idx), font(fr[4*idx +: 4]), (idx != 4)};
    return e;
  endfunction

  function automatic logic [31:0] pick(input logic [1:0] s);
    return (s == 2'd1) ? in_port1 : (s == 2'd2) ? in_port2 : in_port0;
  endfunction

  // Reference model: pushes what the DUT should show after this edge.
  always @(posedge io_clk or posedge clr) begin
    if (clr) begin
      m_cnt   <= 0;
      m_idx   <= 0;
      m_frame <= '0;
    end else begin
      q.push_back(exp_out(m_idx, m_frame, disp_en));
      if (m_cnt == 3) begin
        m_cnt <= 0;
        m_idx <= (m_idx + 1) % 8;
        if (m_idx == 7) m_frame <= pick(disp_sel);
      end else begin
        m_cnt <= m_cnt + 1;
      end
    end
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h (c=%0d)", tag, obs, exp, c);
    end
  endtask

  // One clock: sample at the negedge, compare against the scoreboard.
  task automatic cyc();
    out_t e;
    @(negedge io_clk);
    c++;
    if (clr || q.size() == 0) begin
      chk("reset_out", {an, seg, dp}, {8'hFF, 7'h7F, 1'b1});
      q.delete();
    end else begin
      e = q.pop_front();
      chk("scoreboard", {an, seg, dp}, e);
    end
  endtask

  task automatic run_to(input int t);
    while (c < t) cyc();
  endtask

  initial begin
    logic [15:0] e_dig5, e_dig2, e_zf5;
`ifdef LEADING_ZERO_BLANK_EN
    e_zf5  = {8'hFF, 7'h7F, 1'b1};
    e_dig2 = {8'hFF, 7'h7F, 1'b1};
    e_dig5 = {8'hFF, 7'h7F, 1'b1};
`else
    e_zf5  = {8'hDF, 7'h40, 1'b1};
    e_dig2 = {8'hFB, 7'h40, 1'b1};
    e_dig5 = {8'hDF, 7'h40, 1'b1};
`endif
    cyc(); cyc();
    #2 clr = 1'b0; c = 0;
    in_port1 = 32'h1234ABCD; disp_sel = 2'd1;
    run_to(1);
    chk("first_digit0", {an, seg, dp}, {8'hFE, 7'h40, 1'b1});
    // Second frame shows port 1; disp_sel drops to 0 mid-frame without tearing.
    for (int k = 0; k < 8; k++) begin
      run_to(33 + 4 * k);
      chk("frame1_digit", {an, seg}, {~(8'h1 << k), seg_1234abcd[k]});
      chk("frame1_dp", {15'h0, dp}, {15'h0, (k != 4)});
      if (k == 2) #2 disp_sel = 2'd0;
    end
    // Port 0 jumps to all-F mid-frame: rest of frame stays 0.
    run_to(77); #2 in_port0 = 32'hFFFFFFFF;
    run_to(85); chk("no_tear_zero", {an, seg, dp}, e_zf5);
    run_to(97); chk("all_f_digit0", {an, seg, dp}, {8'hFE, 7'h0E, 1'b1});
    #2 in_port2 = 32'h000000A5;
    run_to(105); #2 disp_sel = 2'd2;
    run_to(121); chk("sel_deferred", {an, seg, dp}, {8'hBF, 7'h0E, 1'b1});
    run_to(125); chk("all_f_digit7", {an, seg, dp}, {8'h7F, 7'h0E, 1'b1});
    run_to(129); chk("sel2_digit0", {an, seg, dp}, {8'hFE, 7'h12, 1'b1});
    run_to(133); chk("sel2_digit1", {an, seg, dp}, {8'hFD, 7'h08, 1'b1});
    run_to(137); chk("sel2_digit2", {an, seg, dp}, e_dig2);
    // Display off for 10 cycles; scan keeps running underneath.
    run_to(140); #2 disp_en = 1'b0;
    run_to(141); chk("disable_dark", {an, seg, dp}, {8'hFF, 7'h7F, 1'b1});
    run_to(150); #2 disp_en = 1'b1;
    run_to(151); chk("reenable_digit5", {an, seg, dp}, e_dig5);
    // Async clear mid-scan: outputs go dark without waiting for a clock.
    run_to(155); #2 clr = 1'b1;
    #1 chk("clr_async", {an, seg, dp}, {8'hFF, 7'h7F, 1'b1});
    cyc(); cyc();
    #2 clr = 1'b0; c = 0;
    run_to(1); chk("post_clr_digit0", {an, seg, dp}, {8'hFE, 7'h40, 1'b1});
    run_to(4); chk("post_clr_hold", {an, seg, dp}, {8'hFE, 7'h40, 1'b1});
    run_to(40);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
